adder_result_accum: RTL



---
 rtl/adder_pkg.sv | 28 ++
 rtl/accum_add.sv | 46 ++++
 rtl/adder_result_accum.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the adder4 result accumulator.
//   - state_t : accumulator FSM states (2-bit encoding)
//   - SUM_W   : width of the adder4 S output
//   - RES_W   : width of one {C4,S} result
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int SUM_W = 4;
    localparam int RES_W = SUM_W + 1;

    // Largest value a single {C4,S} result can carry (15 + 15).
    localparam int RES_MAX = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pack a 4-bit sum and its carry into one result value.
    function automatic logic [RES_W-1:0] make_result(input logic carry,
                                                     input logic [SUM_W-1:0] sum);
        return {carry, sum};
    endfunction

endpackage

// File: rtl/accum_add.sv
// -----------------------------------------------------------------------------
// accum_add
// Combinational ACC_W-bit adder used by adder_result_accum.
// The result value is zero-extended to ACC_W+1 bits so the top bit of the
// sum is the carry-out of the accumulator.
//
// Build option:
//   ADDER_ACCUM_SATURATE_EN defined   : on carry-out, sum_out is forced to
//                                       all ones (2^ACC_W-1).
//   ADDER_ACCUM_SATURATE_EN undefined : sum_out wraps modulo 2^ACC_W.
// carry_out reports the raw carry in both builds.
//
// Ports:
//   acc_in    in   ACC_W  current running total
//   val       in   RES_W  new result to add (0..30)
//   sum_out   out  ACC_W  next running total
//   carry_out out  1      carry-out of the ACC_W-bit add
// -----------------------------------------------------------------------------
module accum_add
    import adder_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [RES_W-1:0] val,
    output logic [ACC_W-1:0] sum_out,
    output logic             carry_out
);

    logic [ACC_W:0] val_ext;
    logic [ACC_W:0] raw_sum;

    assign val_ext   = (ACC_W + 1)'(val);
    assign raw_sum   = {1'b0, acc_in} + val_ext;
    assign carry_out = raw_sum[ACC_W];

`ifdef ADDER_ACCUM_SATURATE_EN
    // Once saturated the total is all ones, so any further non-zero result
    // carries again and a zero result leaves it at all ones: the total stays
    // pinned for the rest of the block without extra state.
    assign sum_out = carry_out ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
    assign sum_out = raw_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/adder_result_accum.sv
// -----------------------------------------------------------------------------
// adder_result_accum
// Downstream stage of adder4. Accepts {C4,S} results, sums BLOCK_LEN of them
// into a block total and offers {acc, count, ovf} to the consumer with a
// valid/ready handshake.
//
// Handshake: a transfer happens on a rising clk edge where both valid and
// ready are high. in_ready is combinational ((state != DONE) & ~clear) and
// does not depend on in_valid; out_valid is registered (state == DONE) and
// once high holds with acc/count/ovf stable until out_ready is seen or the
// block is cleared.
//
// Build option: ADDER_ACCUM_SATURATE_EN selects saturating accumulation
// (see accum_add); handshake and timing are identical in both builds.
//
// Ports:
//   clk        in   1      clock
//   rst        in   1      asynchronous active-high reset
//   clear      in   1      synchronous abort; drops the current block
//   in_valid   in   1      upstream result valid
//   in_ready   out  1      block accepts a result this cycle
//   in_sum     in   4      adder4 S
//   in_carry   in   1      adder4 C4
//   out_valid  out  1      block total available
//   out_ready  in   1      consumer takes the total
//   acc        out  ACC_W  running / final total
//   count      out  CNT_W  results accepted in the current block
//   ovf        out  1      sticky carry-out within the current block
//   dbg_state  out  2      current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module adder_result_accum
    import adder_pkg::*;
#(
    parameter int ACC_W     = 8,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    // -------------------------------------------------------------------------
    // Parameter sanity
    // -------------------------------------------------------------------------
    generate
        if (ACC_W < RES_W) begin : g_bad_acc_w
            $error("adder_result_accum: ACC_W must be >= RES_W");
        end
        if (BLOCK_LEN < 1 || BLOCK_LEN >= (1 << CNT_W)) begin : g_bad_block_len
            $error("adder_result_accum: BLOCK_LEN must be in 1..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BLOCK_LEN);
    localparam bit               SINGLE     = (BLOCK_LEN == 1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q,   ovf_d;

    logic [RES_W-1:0] res_val;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] count_inc;
    logic             accept;
    logic             out_take;

    assign res_val   = make_result(in_carry, in_sum);
    assign count_inc = count_q + CNT_W'(1);

    assign in_ready  = (state_q != DONE) & ~clear;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign out_take  = out_valid & out_ready;

    accum_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_in    (acc_q),
        .val       (res_val),
        .sum_out   (add_sum),
        .carry_out (add_carry)
    );

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (clear) begin
            // Abort wins over any pending output handshake; in_ready is
            // already low so nothing is accepted this cycle.
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // First result of a block loads directly; it can
                        // never carry since ACC_W >= RES_W.
                        acc_d   = ACC_W'(res_val);
                        count_d = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = SINGLE ? DONE : ACCUM;
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        count_d = count_inc;
                        ovf_d   = ovf_q | add_carry;
                        if (count_inc == LAST_COUNT) begin
                            state_d = DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_take) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end

                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc       = acc_q;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
